// File: rtl/gamma_lut_pkg.sv
// gamma_lut_pkg: shared definitions for the gamma lookup pixel path.
//   - DEF_IN_W / DEF_OUT_W: default component widths.
//   - swap_state_e: bank-swap FSM states.
//   - lin(): linear width expansion (left-justify, replicate MSBs to fill).
package gamma_lut_pkg;

  localparam int unsigned DEF_IN_W  = 8;
  localparam int unsigned DEF_OUT_W = 12;

  typedef enum logic {
    ST_IDLE,
    ST_PENDING
  } swap_state_e;

  // Output bit at MSB-relative position m takes x[in_w-1 - (m % in_w)], which
  // repeats the input pattern as often as needed to fill out_w bits.
  // Valid for out_w <= 32; callers keep the low out_w bits.
  function automatic logic [31:0] lin(input logic [31:0] x, input int unsigned in_w,
                                      input int unsigned out_w);
    logic [31:0] r;
    logic [4:0]  dst;
    logic [4:0]  src;
    int unsigned m;
    r = '0;
    for (int unsigned j = 0; j < 32; j++) begin
      if (j < out_w) begin
        m      = out_w - 1 - j;
        dst    = 5'(j);
        src    = 5'(in_w - 1 - (m % in_w));
        r[dst] = x[src];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/gamma_lut_bank_ram.sv
// gamma_lut_bank_ram: two banks of 2^IN_W x OUT_W table storage.
//   clk_i      : write clock
//   wr_*_i     : single synchronous write port (bank, address, data)
//   rd_bank_i  : per-port bank select, NumRd ports
//   rd_addr_i  : per-port address, port k = bits [k*IN_W +: IN_W]
//   rd_data_o  : per-port combinational read data, port k = bits [k*OUT_W +: OUT_W]
// Contents are not reset.
module gamma_lut_bank_ram #(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned OUT_W = 12,
  parameter int unsigned NumRd = 3
) (
  input  logic                   clk_i,
  input  logic                   wr_en_i,
  input  logic                   wr_bank_i,
  input  logic [IN_W-1:0]        wr_addr_i,
  input  logic [OUT_W-1:0]       wr_data_i,
  input  logic [NumRd-1:0]       rd_bank_i,
  input  logic [NumRd*IN_W-1:0]  rd_addr_i,
  output logic [NumRd*OUT_W-1:0] rd_data_o
);

  localparam int unsigned Entries = 2 ** (IN_W + 1);

  logic [OUT_W-1:0] mem [Entries];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem[{wr_bank_i, wr_addr_i}] <= wr_data_i;
    end
  end

  always_comb begin
    rd_data_o = '0;
    for (int unsigned k = 0; k < NumRd; k++) begin
      rd_data_o[k*OUT_W +: OUT_W] = mem[{rd_bank_i[k], rd_addr_i[k*IN_W +: IN_W]}];
    end
  end

endmodule

// File: rtl/gamma_lut_pp.sv
// gamma_lut_pp: programmable multi-lane gamma lookup with double-banked table.
//   I_clk / I_rst         : clock, asynchronous active-high reset
//   I_vs / I_de / I_data  : frame sync, pixel valid, CH packed IN_W lanes
//   O_vs / O_de / O_data  : same, 2-cycle latency, CH packed OUT_W lanes
//   I_bypass              : force linear mapping (sampled per pixel)
//   I_cfg_wr/addr/data    : write into the shadow (inactive) bank
//   I_cfg_commit          : request bank swap at the next vs rising edge
//   O_commit_pending      : swap requested, not yet applied
//   O_active_bank         : bank used by the datapath
//   O_table_valid         : at least one swap applied since reset
// Build option GAMMA_LUT_READBACK_EN adds I_cfg_rd / O_cfg_rdata / O_cfg_rvalid,
// a registered read of the shadow bank.
module gamma_lut_pp
  import gamma_lut_pkg::*;
#(
  parameter int unsigned IN_W  = DEF_IN_W,
  parameter int unsigned OUT_W = DEF_OUT_W,
  parameter int unsigned CH    = 3
) (
  input  logic                  I_clk,
  input  logic                  I_rst,
  input  logic                  I_vs,
  input  logic                  I_de,
  input  logic [CH*IN_W-1:0]    I_data,
  output logic                  O_vs,
  output logic                  O_de,
  output logic [CH*OUT_W-1:0]   O_data,
  input  logic                  I_bypass,
  input  logic                  I_cfg_wr,
  input  logic [IN_W-1:0]       I_cfg_addr,
  input  logic [OUT_W-1:0]      I_cfg_data,
  input  logic                  I_cfg_commit,
`ifdef GAMMA_LUT_READBACK_EN
  input  logic                  I_cfg_rd,
  output logic [OUT_W-1:0]      O_cfg_rdata,
  output logic                  O_cfg_rvalid,
`endif
  output logic                  O_commit_pending,
  output logic                  O_active_bank,
  output logic                  O_table_valid
);

`ifdef GAMMA_LUT_READBACK_EN
  localparam int unsigned NumRd = CH + 1;
`else
  localparam int unsigned NumRd = CH;
`endif

  // Swap FSM and bank state
  swap_state_e state_q, state_d;
  logic        active_bank_q, active_bank_d;
  logic        table_valid_q, table_valid_d;
  logic        swap;
  logic        vs_rise;

  // S1 / S2 pipeline
  logic [CH*IN_W-1:0]  lane_s1_q, lane_s1_d;
  logic                vs_s1_q, vs_s1_d;
  logic                de_s1_q, de_s1_d;
  logic                lin_s1_q, lin_s1_d;
  logic                bank_s1_q, bank_s1_d;
  logic                vs_s2_q, vs_s2_d;
  logic                de_s2_q, de_s2_d;
  logic [CH*OUT_W-1:0] data_s2_q, data_s2_d;

  logic [NumRd-1:0]       rd_bank;
  logic [NumRd*IN_W-1:0]  rd_addr;
  logic [NumRd*OUT_W-1:0] rd_data;

  // vs_s1_q doubles as the edge-detector history; it resets to 0 so a vs held
  // high out of reset is seen as a rising edge.
  assign vs_rise = I_vs & ~vs_s1_q;

  // FSM state register
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      state_q       <= ST_IDLE;
      active_bank_q <= 1'b0;
      table_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      active_bank_q <= active_bank_d;
      table_valid_q <= table_valid_d;
    end
  end

  // FSM next state; a commit coinciding with a vs rise swaps immediately.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (I_cfg_commit && !vs_rise) state_d = ST_PENDING;
      ST_PENDING: if (vs_rise) state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    swap          = vs_rise && ((state_q == ST_PENDING) || I_cfg_commit);
    active_bank_d = active_bank_q ^ swap;
    table_valid_d = table_valid_q | swap;
  end

  assign O_commit_pending = (state_q == ST_PENDING);
  assign O_active_bank    = active_bank_q;
  assign O_table_valid    = table_valid_q;

  // S1 captures the bank and mode so in-flight pixels keep their mapping across a swap.
  always_comb begin
    lane_s1_d = I_data;
    vs_s1_d   = I_vs;
    de_s1_d   = I_de;
    lin_s1_d  = I_bypass | ~table_valid_q;
    bank_s1_d = active_bank_q;
  end

  always_comb begin
    rd_bank = '0;
    rd_addr = '0;
    for (int unsigned k = 0; k < CH; k++) begin
      rd_bank[k]                = bank_s1_q;
      rd_addr[k*IN_W +: IN_W]   = lane_s1_q[k*IN_W +: IN_W];
    end
`ifdef GAMMA_LUT_READBACK_EN
    rd_bank[CH]               = ~active_bank_q;
    rd_addr[CH*IN_W +: IN_W]  = I_cfg_addr;
`endif
  end

  gamma_lut_bank_ram #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .NumRd (NumRd)
  ) u_ram (
    .clk_i     (I_clk),
    .wr_en_i   (I_cfg_wr),
    .wr_bank_i (~active_bank_q),
    .wr_addr_i (I_cfg_addr),
    .wr_data_i (I_cfg_data),
    .rd_bank_i (rd_bank),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  always_comb begin
    logic [31:0] lin_val;
    lin_val   = '0;
    vs_s2_d   = vs_s1_q;
    de_s2_d   = de_s1_q;
    data_s2_d = '0;
    for (int unsigned k = 0; k < CH; k++) begin
      lin_val = lin(32'(lane_s1_q[k*IN_W +: IN_W]), IN_W, OUT_W);
      data_s2_d[k*OUT_W +: OUT_W] = lin_s1_q ? lin_val[OUT_W-1:0] : rd_data[k*OUT_W +: OUT_W];
    end
  end

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      lane_s1_q <= '0;
      vs_s1_q   <= 1'b0;
      de_s1_q   <= 1'b0;
      lin_s1_q  <= 1'b0;
      bank_s1_q <= 1'b0;
      vs_s2_q   <= 1'b0;
      de_s2_q   <= 1'b0;
      data_s2_q <= '0;
    end else begin
      lane_s1_q <= lane_s1_d;
      vs_s1_q   <= vs_s1_d;
      de_s1_q   <= de_s1_d;
      lin_s1_q  <= lin_s1_d;
      bank_s1_q <= bank_s1_d;
      vs_s2_q   <= vs_s2_d;
      de_s2_q   <= de_s2_d;
      data_s2_q <= data_s2_d;
    end
  end

  assign O_vs   = vs_s2_q;
  assign O_de   = de_s2_q;
  assign O_data = data_s2_q;

`ifdef GAMMA_LUT_READBACK_EN
  // Combinational RAM read sampled at the edge, so a same-cycle write returns old data.
  logic [OUT_W-1:0] rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;

  always_comb begin
    rvalid_d = I_cfg_rd;
    rdata_d  = I_cfg_rd ? rd_data[CH*OUT_W +: OUT_W] : rdata_q;
  end

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign O_cfg_rdata  = rdata_q;
  assign O_cfg_rvalid = rvalid_q;
`endif

endmodule

// File: tb/tb_gamma_lut_pp.sv
// Directed self-checking bench for gamma_lut_pp (IN_W=8, OUT_W=12, CH=3).
module tb_gamma_lut_pp;

  logic        clk;
  logic        rst;
  logic        vs;
  logic        de;
  logic [23:0] din;
  logic        o_vs;
  logic        o_de;
  logic [35:0] o_data;
  logic        bypass;
  logic        cfg_wr;
  logic [7:0]  cfg_addr;
  logic [11:0] cfg_data;
  logic        cfg_commit;
  logic        pending;
  logic        active_bank;
  logic        table_valid;
`ifdef GAMMA_LUT_READBACK_EN
  logic        cfg_rd;
  logic [11:0] cfg_rdata;
  logic        cfg_rvalid;
`endif

  int total;
  int bad;

  gamma_lut_pp #(
    .IN_W  (8),
    .OUT_W (12),
    .CH    (3)
  ) dut (
    .I_clk            (clk),
    .I_rst            (rst),
    .I_vs             (vs),
    .I_de             (de),
    .I_data           (din),
    .O_vs             (o_vs),
    .O_de             (o_de),
    .O_data           (o_data),
    .I_bypass         (bypass),
    .I_cfg_wr         (cfg_wr),
    .I_cfg_addr       (cfg_addr),
    .I_cfg_data       (cfg_data),
    .I_cfg_commit     (cfg_commit),
`ifdef GAMMA_LUT_READBACK_EN
    .I_cfg_rd         (cfg_rd),
    .O_cfg_rdata      (cfg_rdata),
    .O_cfg_rvalid     (cfg_rvalid),
`endif
    .O_commit_pending (pending),
    .O_active_bank    (active_bank),
    .O_table_valid    (table_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; vs = 1'b0; de = 1'b0; din = '0; bypass = 1'b0;
    cfg_wr = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_commit = 1'b0;
`ifdef GAMMA_LUT_READBACK_EN
    cfg_rd = 1'b0;
`endif
    tick();
    tick();
    total++;
    if ({o_vs, o_de, pending, active_bank, table_valid} !== 5'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b exp=00000", {o_vs, o_de, pending, active_bank, table_valid});
    end
    total++;
    if (o_data !== 36'd0) begin
      bad++; $display("FAIL reset_data got=%h exp=0", o_data);
    end
`ifdef GAMMA_LUT_READBACK_EN
    total++;
    if ({cfg_rvalid, cfg_rdata} !== 13'd0) begin
      bad++; $display("FAIL reset_rb got=%h exp=0", {cfg_rvalid, cfg_rdata});
    end
`endif
    rst = 1'b0;
  endtask

  // Table not valid yet: linear mapping on all lanes.
  task automatic test_linear();
    de = 1'b1; din = {8'd200, 8'd1, 8'd0};
    tick();
    din = {8'd0, 8'd255, 8'd128};
    tick();
    total++;
    if (o_data !== {12'd3212, 12'd16, 12'd0}) begin
      bad++; $display("FAIL lin_pix0 got=%h exp=%h", o_data, {12'd3212, 12'd16, 12'd0});
    end
    din = {8'd128, 8'd64, 8'd255};
    tick();
    total++;
    if (o_data !== {12'd0, 12'd4095, 12'd2056}) begin
      bad++; $display("FAIL lin_pix1 got=%h exp=%h", o_data, {12'd0, 12'd4095, 12'd2056});
    end
    de = 1'b0;
    tick();
    total++;
    if (o_data !== {12'd2056, 12'd1028, 12'd4095} || o_de !== 1'b1) begin
      bad++; $display("FAIL lin_pix2 got=%h/%b exp=%h/1", o_data, o_de, {12'd2056, 12'd1028, 12'd4095});
    end
    tick();
    total++;
    if (o_de !== 1'b0 || table_valid !== 1'b0) begin
      bad++; $display("FAIL lin_tail de/valid got=%b%b exp=00", o_de, table_valid);
    end
  endtask

  // Load bank 1 with 4095-16x, commit, swap on vs rise.
  task automatic test_load_swap();
    for (int x = 0; x < 256; x++) begin
      cfg_wr = 1'b1; cfg_addr = 8'(x); cfg_data = 12'(4095 - 16 * x);
      tick();
    end
    cfg_wr = 1'b0;
`ifdef GAMMA_LUT_READBACK_EN
    cfg_rd = 1'b1; cfg_addr = 8'd10;
    tick();
    cfg_rd = 1'b0;
    total++;
    if (cfg_rvalid !== 1'b1 || cfg_rdata !== 12'd3935) begin
      bad++; $display("FAIL rb_read got=%b/%0d exp=1/3935", cfg_rvalid, cfg_rdata);
    end
    cfg_rd = 1'b1; cfg_wr = 1'b1; cfg_data = 12'd999;
    tick();
    total++;
    if (cfg_rdata !== 12'd3935) begin
      bad++; $display("FAIL rb_rd_wr_old got=%0d exp=3935", cfg_rdata);
    end
    cfg_wr = 1'b0;
    tick();
    total++;
    if (cfg_rdata !== 12'd999) begin
      bad++; $display("FAIL rb_new got=%0d exp=999", cfg_rdata);
    end
    cfg_rd = 1'b0; cfg_wr = 1'b1; cfg_data = 12'd3935;
    tick();
    cfg_wr = 1'b0;
    tick();
    total++;
    if (cfg_rvalid !== 1'b0) begin
      bad++; $display("FAIL rb_rvalid_low got=%b exp=0", cfg_rvalid);
    end
`endif
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    total++;
    if ({pending, active_bank, table_valid} !== 3'b100) begin
      bad++; $display("FAIL commit_pend got=%b exp=100", {pending, active_bank, table_valid});
    end
    vs = 1'b1;
    tick();
    total++;
    if ({pending, active_bank, table_valid} !== 3'b011) begin
      bad++; $display("FAIL swap1 got=%b exp=011", {pending, active_bank, table_valid});
    end
    de = 1'b1; din = {8'd255, 8'd0, 8'd10};
    tick();
    de = 1'b0;
    tick();
    total++;
    if (o_data !== {12'd15, 12'd4095, 12'd3935} || o_vs !== 1'b1) begin
      bad++; $display("FAIL table_map got=%h/%b exp=%h/1", o_data, o_vs, {12'd15, 12'd4095, 12'd3935});
    end
  endtask

  // Commit mid-frame: old mapping until the next vs rise.
  task automatic test_commit_midframe();
    cfg_wr = 1'b1; cfg_addr = 8'd10; cfg_data = 12'd7;
    tick();
    cfg_addr = 8'd64; cfg_data = 12'd100;
    tick();
    cfg_wr = 1'b0;
    vs = 1'b0;
    tick();
    de = 1'b1; din = {8'd10, 8'd10, 8'd10};
    tick();
    tick();
    total++;
    if (o_data !== {12'd3935, 12'd3935, 12'd3935}) begin
      bad++; $display("FAIL mid_before got=%h exp=%h", o_data, {12'd3935, 12'd3935, 12'd3935});
    end
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    total++;
    if ({pending, active_bank} !== 2'b11) begin
      bad++; $display("FAIL mid_pending got=%b exp=11", {pending, active_bank});
    end
    tick();
    total++;
    if (o_data !== {12'd3935, 12'd3935, 12'd3935}) begin
      bad++; $display("FAIL mid_oldmap got=%h exp=%h", o_data, {12'd3935, 12'd3935, 12'd3935});
    end
    de = 1'b0;
    tick();
    total++;
    if (pending !== 1'b1) begin
      bad++; $display("FAIL mid_hold got=%b exp=1", pending);
    end
    vs = 1'b1;
    tick();
    total++;
    if ({pending, active_bank, table_valid} !== 3'b001) begin
      bad++; $display("FAIL mid_swap got=%b exp=001", {pending, active_bank, table_valid});
    end
    de = 1'b1;
    tick();
    de = 1'b0;
    tick();
    total++;
    if (o_data !== {12'd7, 12'd7, 12'd7}) begin
      bad++; $display("FAIL mid_newmap got=%h exp=%h", o_data, {12'd7, 12'd7, 12'd7});
    end
  endtask

  // Commit on the vs edge swaps at once; extra commits while pending do not double-toggle.
  task automatic test_commit_on_edge();
    vs = 1'b0;
    tick();
    vs = 1'b1; cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    total++;
    if ({pending, active_bank} !== 2'b01) begin
      bad++; $display("FAIL edge_swap got=%b exp=01", {pending, active_bank});
    end
    cfg_commit = 1'b1;
    tick();
    tick();
    cfg_commit = 1'b0;
    total++;
    if ({pending, active_bank} !== 2'b11) begin
      bad++; $display("FAIL edge_recommit got=%b exp=11", {pending, active_bank});
    end
    vs = 1'b0;
    tick();
    vs = 1'b1;
    tick();
    total++;
    if ({pending, active_bank} !== 2'b00) begin
      bad++; $display("FAIL edge_single got=%b exp=00", {pending, active_bank});
    end
    vs = 1'b0;
    tick();
    vs = 1'b1;
    tick();
    total++;
    if ({pending, active_bank} !== 2'b00) begin
      bad++; $display("FAIL idle_rise got=%b exp=00", {pending, active_bank});
    end
  endtask

  // One bypassed pixel in a stream of 64 (table[64]=100).
  task automatic test_bypass();
    de = 1'b1; din = {8'd64, 8'd64, 8'd64}; bypass = 1'b0;
    tick();
    bypass = 1'b1;
    tick();
    total++;
    if (o_data !== {12'd100, 12'd100, 12'd100}) begin
      bad++; $display("FAIL byp_p0 got=%h exp=%h", o_data, {12'd100, 12'd100, 12'd100});
    end
    bypass = 1'b0;
    tick();
    total++;
    if (o_data !== {12'd1028, 12'd1028, 12'd1028}) begin
      bad++; $display("FAIL byp_p1 got=%h exp=%h", o_data, {12'd1028, 12'd1028, 12'd1028});
    end
    de = 1'b0;
    tick();
    total++;
    if (o_data !== {12'd100, 12'd100, 12'd100}) begin
      bad++; $display("FAIL byp_p2 got=%h exp=%h", o_data, {12'd100, 12'd100, 12'd100});
    end
  endtask

  // Asynchronous reset mid-frame returns to linear mapping.
  task automatic test_reset_midframe();
    vs = 1'b1; de = 1'b1; din = {8'd64, 8'd64, 8'd64};
    tick();
    tick();
    total++;
    if ({o_vs, o_de} !== 2'b11 || o_data !== {12'd100, 12'd100, 12'd100}) begin
      bad++; $display("FAIL pre_rst got=%b/%h exp=11/%h", {o_vs, o_de}, o_data, {12'd100, 12'd100, 12'd100});
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({o_vs, o_de, table_valid, active_bank, pending} !== 5'b0 || o_data !== 36'd0) begin
      bad++; $display("FAIL async_rst got=%b/%h exp=00000/0", {o_vs, o_de, table_valid, active_bank, pending}, o_data);
    end
    tick();
    rst = 1'b0;
    tick();
    tick();
    total++;
    if (o_data !== {12'd1028, 12'd1028, 12'd1028} || o_de !== 1'b1 || table_valid !== 1'b0) begin
      bad++; $display("FAIL post_rst_lin got=%h/%b%b exp=%h/10", o_data, o_de, table_valid, {12'd1028, 12'd1028, 12'd1028});
    end
    de = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_linear();
    test_load_swap();
    test_commit_midframe();
    test_commit_on_edge();
    test_bypass();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
